// File: rtl/lio_axi_pkg.sv
// Shared AXI4 read-channel definitions for the lio_axi blocks.
// Defines field widths, field order and payload width helpers.
package lio_axi_pkg;

   // AR control field widths. The full AR payload is
   // {id, addr, len, size, burst, lock, cache, prot, qos, region}, MSB first.
   localparam int LEN_W    = 8;
   localparam int SIZE_W   = 3;
   localparam int BURST_W  = 2;
   localparam int LOCK_W   = 1;
   localparam int CACHE_W  = 4;
   localparam int PROT_W   = 3;
   localparam int QOS_W    = 4;
   localparam int REGION_W = 4;
   localparam int AR_CTRL_W = LEN_W + SIZE_W + BURST_W + LOCK_W + CACHE_W
                            + PROT_W + QOS_W + REGION_W;

   // R payload is {id, data, resp, last}, MSB first.
   localparam int RESP_W     = 2;
   localparam int R_LAST_BIT = 0;

   // The id field sits at the top of both payloads, so a port index can be
   // prepended or stripped by plain concatenation/slicing.
   function automatic int ar_width(input int addr_w, input int id_w);
      return id_w + addr_w + AR_CTRL_W;
   endfunction

   function automatic int r_width(input int data_w, input int id_w);
      return id_w + data_w + RESP_W + 1;
   endfunction

endpackage

// File: rtl/lio_rr_arb.sv
// Generic N-request round-robin arbiter.
// Searches from the port after the last winner; the pointer moves only when
// the grant is accepted (advance), so an un-granted request keeps its place.
module lio_rr_arb #(
   parameter int N     = 2,
   parameter int IDX_W = $clog2(N)
) (
   input  logic             aclk,
   input  logic             arstn,
   input  logic [N-1:0]     req,
   input  logic             advance,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             any_grant
);

   logic [IDX_W-1:0] ptr;

   // Pick the first requester after ptr, wrapping N-1 -> 0.
   always_comb begin
      int unsigned      cand;
      logic [IDX_W-1:0] cand_idx;
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      cand      = 0;
      cand_idx  = '0;
      for (int k = 1; k <= N; k++) begin
         cand = int'(ptr) + k;
         if (cand >= N) cand = cand - N;
         cand_idx = IDX_W'(cand);
         if (!any_grant && req[cand_idx]) begin
            any_grant       = 1'b1;
            grant[cand_idx] = 1'b1;
            grant_idx       = cand_idx;
         end
      end
   end

   // Pointer register; resets to N-1 so port 0 wins the first arbitration.
   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn)
         ptr <= IDX_W'(N - 1);
      else if (advance && any_grant)
         ptr <= grant_idx;
   end

endmodule

// File: rtl/lio_axi_rd_arb.sv
// N:1 AXI4 read-path arbiter: round-robin AR with a registered output stage,
// R beats routed back by the port index carried in the top ID bits, and a
// per-requester outstanding-burst limit.
module lio_axi_rd_arb
   import lio_axi_pkg::*;
#(
   parameter  int N_PORTS    = 2,
   parameter  int ADDR_WIDTH = 32,
   parameter  int DATA_WIDTH = 32,
   parameter  int ID_WIDTH   = 4,
   parameter  int MAX_OUTST  = 4,
   localparam int IDX_W      = $clog2(N_PORTS),
   localparam int AR_W       = ar_width(ADDR_WIDTH, ID_WIDTH),
   localparam int R_W        = r_width(DATA_WIDTH, ID_WIDTH)
) (
   input  logic                      aclk,
   input  logic                      arstn,
   input  logic [N_PORTS*AR_W-1:0]   s_ar_pld,
   input  logic [N_PORTS-1:0]        s_arvalid,
   output logic [N_PORTS-1:0]        s_arready,
   output logic [R_W-1:0]            s_r_pld,
   output logic [N_PORTS-1:0]        s_rvalid,
   input  logic [N_PORTS-1:0]        s_rready,
   output logic [AR_W+IDX_W-1:0]     m_ar_pld,
   output logic                      m_arvalid,
   input  logic                      m_arready,
   input  logic [R_W+IDX_W-1:0]      m_r_pld,
   input  logic                      m_rvalid,
   output logic                      m_rready,
   output logic                      route_err
);

   localparam int CNT_W = $clog2(MAX_OUTST + 1);

   logic [AR_W-1:0]    ar_pld_arr [N_PORTS];
   logic [CNT_W-1:0]   cnt        [N_PORTS];
   logic [N_PORTS-1:0] eligible, grant, inc, dec, dec_req, sel_hit;
   logic [IDX_W-1:0]   grant_idx, sel;
   logic               any_grant, slot_free, advance, route_ok, rlast, r_fire;

   // Unpack per-port payloads and mask ports that hit their outstanding limit.
   // Eligibility uses the registered count, so a same-cycle retire does not help.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         ar_pld_arr[i] = s_ar_pld[i*AR_W +: AR_W];
         eligible[i]   = s_arvalid[i] && (cnt[i] < CNT_W'(MAX_OUTST));
      end
   end

   lio_rr_arb #(.N(N_PORTS), .IDX_W(IDX_W)) u_rr (
      .aclk      (aclk),
      .arstn     (arstn),
      .req       (eligible),
      .advance   (advance),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_grant (any_grant)
   );

   assign slot_free = !m_arvalid || m_arready;
   assign advance   = slot_free && any_grant;
   assign s_arready = slot_free ? grant : '0;
   assign inc       = advance ? grant : '0;

   // Output stage: load a new AR when the slot frees, otherwise hold it stable.
   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         m_arvalid <= 1'b0;
         m_ar_pld  <= '0;
      end else if (slot_free) begin
         m_arvalid <= any_grant;
         if (any_grant)
            m_ar_pld <= {grant_idx, ar_pld_arr[grant_idx]};
      end
   end

   // R routing: port index sits above the requester ID and is stripped here.
   assign sel     = m_r_pld[R_W +: IDX_W];
   assign rlast   = m_r_pld[R_LAST_BIT];
   assign s_r_pld = m_r_pld[R_W-1:0];

   // Out-of-range indices exist only when N_PORTS is not a power of two.
   if ((1 << IDX_W) == N_PORTS) begin : g_route_pow2
      assign route_ok = 1'b1;
   end else begin : g_route_chk
      assign route_ok = (sel <= IDX_W'(N_PORTS - 1));
   end

   // Decode the destination port of the current R beat.
   always_comb begin
      sel_hit = '0;
      for (int i = 0; i < N_PORTS; i++)
         sel_hit[i] = route_ok && (sel == IDX_W'(i));
   end

   assign s_rvalid = {N_PORTS{m_rvalid}} & sel_hit;
   // A bad route is accepted and dropped so the downstream never stalls on it.
   assign m_rready = route_ok ? |(s_rready & sel_hit) : 1'b1;
   assign r_fire   = m_rvalid && m_rready;
   assign dec_req  = {N_PORTS{r_fire && rlast}} & sel_hit;

   // Late beats after a reset must not wrap a counter below zero.
   always_comb begin
      dec = '0;
      for (int i = 0; i < N_PORTS; i++)
         dec[i] = dec_req[i] && (cnt[i] != '0);
   end

   // Outstanding-burst counters; simultaneous inc and dec cancel out.
   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         for (int i = 0; i < N_PORTS; i++)
            cnt[i] <= '0;
      end else begin
         for (int i = 0; i < N_PORTS; i++) begin
            if (inc[i] && !dec[i])
               cnt[i] <= cnt[i] + 1'b1;
            else if (dec[i] && !inc[i])
               cnt[i] <= cnt[i] - 1'b1;
         end
      end
   end

   // One-cycle flag for a dropped, mis-routed R beat.
   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn)
         route_err <= 1'b0;
      else
         route_err <= m_rvalid && !route_ok;
   end

   // Counters must never be asked to move past their limits.
   for (genvar i = 0; i < N_PORTS; i++) begin : g_chk
      a_no_underflow : assert property (@(posedge aclk) disable iff (!arstn)
         !(dec_req[i] && cnt[i] == '0));
      a_no_overflow  : assert property (@(posedge aclk) disable iff (!arstn)
         !(inc[i] && cnt[i] == CNT_W'(MAX_OUTST)));
   end

endmodule

// File: tb/tb_lio_axi_rd_arb.sv
// Directed self-checking bench for lio_axi_rd_arb.
// Instance A: 2 ports, limit 4. Instance B: 3 ports, limit 2.
module tb_lio_axi_rd_arb;
   import lio_axi_pkg::*;

   localparam int AR_W = ar_width(32, 4);
   localparam int R_W  = r_width(32, 4);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Instance A signals (N=2, IDX_W=1)
   logic               a_rstn;
   logic [2*AR_W-1:0]  a_s_ar_pld;
   logic [1:0]         a_s_arvalid, a_s_arready, a_s_rvalid, a_s_rready;
   logic [R_W-1:0]     a_s_r_pld;
   logic [AR_W:0]      a_m_ar_pld;
   logic               a_m_arvalid, a_m_arready, a_m_rvalid, a_m_rready, a_route_err;
   logic [R_W:0]       a_m_r_pld;

   // Instance B signals (N=3, IDX_W=2)
   logic               b_rstn;
   logic [3*AR_W-1:0]  b_s_ar_pld;
   logic [2:0]         b_s_arvalid, b_s_arready, b_s_rvalid, b_s_rready;
   logic [R_W-1:0]     b_s_r_pld;
   logic [AR_W+1:0]    b_m_ar_pld;
   logic               b_m_arvalid, b_m_arready, b_m_rvalid, b_m_rready, b_route_err;
   logic [R_W+1:0]     b_m_r_pld;

   lio_axi_rd_arb #(.N_PORTS(2), .MAX_OUTST(4)) dut_a (
      .aclk(clk), .arstn(a_rstn),
      .s_ar_pld(a_s_ar_pld), .s_arvalid(a_s_arvalid), .s_arready(a_s_arready),
      .s_r_pld(a_s_r_pld), .s_rvalid(a_s_rvalid), .s_rready(a_s_rready),
      .m_ar_pld(a_m_ar_pld), .m_arvalid(a_m_arvalid), .m_arready(a_m_arready),
      .m_r_pld(a_m_r_pld), .m_rvalid(a_m_rvalid), .m_rready(a_m_rready),
      .route_err(a_route_err)
   );

   lio_axi_rd_arb #(.N_PORTS(3), .MAX_OUTST(2)) dut_b (
      .aclk(clk), .arstn(b_rstn),
      .s_ar_pld(b_s_ar_pld), .s_arvalid(b_s_arvalid), .s_arready(b_s_arready),
      .s_r_pld(b_s_r_pld), .s_rvalid(b_s_rvalid), .s_rready(b_s_rready),
      .m_ar_pld(b_m_ar_pld), .m_arvalid(b_m_arvalid), .m_arready(b_m_arready),
      .m_r_pld(b_m_r_pld), .m_rvalid(b_m_rvalid), .m_rready(b_m_rready),
      .route_err(b_route_err)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   logic [AR_W-1:0] pa0, pa1, pb0, pb1, pb2;
   logic [31:0]     rdata;

   initial begin
      pa0 = {4'h1, 32'h1000_0010, 29'h0ABCDEF};
      pa1 = {4'h2, 32'h2000_0020, 29'h0123456};
      pb0 = {4'h3, 32'h3000_0030, 29'h0111111};
      pb1 = {4'h4, 32'h4000_0040, 29'h0222222};
      pb2 = {4'h5, 32'h5000_0050, 29'h0333333};
      rdata = 32'hCAFE_F00D;

      a_rstn = 1'b0; b_rstn = 1'b0;
      a_s_ar_pld = {pa1, pa0}; a_s_arvalid = '0; a_s_rready = '0;
      a_m_arready = 1'b0; a_m_r_pld = '0; a_m_rvalid = 1'b0;
      b_s_ar_pld = {pb2, pb1, pb0}; b_s_arvalid = '0; b_s_rready = '0;
      b_m_arready = 1'b0; b_m_r_pld = '0; b_m_rvalid = 1'b0;
      tick(); tick();
      a_rstn = 1'b1; b_rstn = 1'b1;
      settle();

      // Reset state
      check("rst_a_arvalid", a_m_arvalid, 0);
      check("rst_a_arpld",   a_m_ar_pld, 0);
      check("rst_a_rerr",    a_route_err, 0);
      check("rst_b_arvalid", b_m_arvalid, 0);
      check("rst_b_rerr",    b_route_err, 0);

      // Test 1: both ports requesting, m_arready high -> 0,1,0,1 at one AR/cycle
      a_s_arvalid = 2'b11; a_m_arready = 1'b1;
      settle();
      check("t1_ready0", a_s_arready, 2'b01);
      tick();
      check("t1_vld0", a_m_arvalid, 1);
      check("t1_pld0", a_m_ar_pld, {1'b0, pa0});
      check("t1_ready1", a_s_arready, 2'b10);
      tick();
      check("t1_pld1", a_m_ar_pld, {1'b1, pa1});
      check("t1_ready2", a_s_arready, 2'b01);
      tick();
      check("t1_pld2", a_m_ar_pld, {1'b0, pa0});
      tick();
      check("t1_pld3", a_m_ar_pld, {1'b1, pa1});

      // Test 2: master stalls for 5 cycles -> payload held, no grants
      a_m_arready = 1'b0;
      settle();
      check("t2_ready_stall", a_s_arready, 2'b00);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t2_vld_hold", a_m_arvalid, 1);
         check("t2_pld_hold", a_m_ar_pld, {1'b1, pa1});
         check("t2_ready_hold", a_s_arready, 2'b00);
      end
      a_m_arready = 1'b1;
      settle();
      check("t2_ready_rel", a_s_arready, 2'b01);
      tick();
      check("t2_pld_rel", a_m_ar_pld, {1'b0, pa0});
      a_s_arvalid = 2'b00;
      settle();
      check("t2_ready_idle", a_s_arready, 2'b00);
      tick();
      check("t2_vld_drop", a_m_arvalid, 0);
      check("t2_cnt0", dut_a.cnt[0], 3);
      check("t2_cnt1", dut_a.cnt[1], 2);

      // Test 4: R beat for port 1 held off by s_rready, then accepted
      a_m_r_pld = {1'b1, 4'h3, rdata, 2'b00, 1'b1};
      a_m_rvalid = 1'b1; a_s_rready = 2'b00;
      settle();
      check("t4_rvalid", a_s_rvalid, 2'b10);
      check("t4_rready", a_m_rready, 0);
      check("t4_rpld", a_s_r_pld, {4'h3, rdata, 2'b00, 1'b1});
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t4_rvalid_hold", a_s_rvalid, 2'b10);
         check("t4_rready_hold", a_m_rready, 0);
         check("t4_cnt_hold", dut_a.cnt[1], 2);
      end
      a_s_rready = 2'b10;
      settle();
      check("t4_rready_acc", a_m_rready, 1);
      tick();
      a_m_rvalid = 1'b0; a_s_rready = 2'b00;
      check("t4_cnt_dec", dut_a.cnt[1], 1);
      tick();
      check("t4_cnt_once", dut_a.cnt[1], 1);

      // Test 6: reset mid-traffic clears everything asynchronously
      a_s_arvalid = 2'b11;
      tick();
      check("t6_pld_pre", a_m_ar_pld, {1'b1, pa1});
      check("t6_cnt_pre", dut_a.cnt[1], 2);
      #2;
      a_rstn = 1'b0;
      settle();
      check("t6_vld_rst", a_m_arvalid, 0);
      check("t6_cnt0_rst", dut_a.cnt[0], 0);
      check("t6_cnt1_rst", dut_a.cnt[1], 0);
      tick();
      a_rstn = 1'b1;
      settle();
      check("t6_ready_first", a_s_arready, 2'b01);
      tick();
      check("t6_pld_first", a_m_ar_pld, {1'b0, pa0});
      a_s_arvalid = 2'b00;

      // Test 3 (N=3, limit 2): port 0 saturates, port 1 still served
      b_m_arready = 1'b1; b_s_arvalid = 3'b001;
      settle();
      check("t3_ready_a", b_s_arready, 3'b001);
      tick();
      check("t3_pld_a", b_m_ar_pld, {2'd0, pb0});
      settle();
      check("t3_ready_b", b_s_arready, 3'b001);
      tick();
      b_s_arvalid = 3'b011;
      settle();
      check("t3_p0_stall", b_s_arready, 3'b010);
      tick();
      check("t3_pld_p1", b_m_ar_pld, {2'd1, pb1});
      check("t3_cnt0_full", dut_b.cnt[0], 2);
      settle();
      check("t3_ready_p1b", b_s_arready, 3'b010);
      tick();
      settle();
      check("t3_all_full", b_s_arready, 3'b000);
      b_m_r_pld = {2'd0, 4'h0, rdata, 2'b00, 1'b1};
      b_m_rvalid = 1'b1; b_s_rready = 3'b111;
      settle();
      check("t3_retire_same", b_s_arready, 3'b000);
      check("t3_rvalid", b_s_rvalid, 3'b001);
      check("t3_rready", b_m_rready, 1);
      tick();
      b_m_rvalid = 1'b0;
      settle();
      check("t3_regrant", b_s_arready, 3'b001);
      tick();
      check("t3_pld_regrant", b_m_ar_pld, {2'd0, pb0});
      check("t3_vld_regrant", b_m_arvalid, 1);
      b_s_arvalid = 3'b000;

      // Test 5 (N=3): prefix 3 is out of range -> drop and flag
      b_m_r_pld = {2'd3, 4'h5, rdata, 2'b10, 1'b1};
      b_m_rvalid = 1'b1; b_s_rready = 3'b000;
      settle();
      check("t5_rready", b_m_rready, 1);
      check("t5_no_rvalid", b_s_rvalid, 3'b000);
      tick();
      b_m_rvalid = 1'b0;
      check("t5_rerr_pulse", b_route_err, 1);
      tick();
      check("t5_rerr_clear", b_route_err, 0);
      check("t5_cnt0", dut_b.cnt[0], 2);
      check("t5_cnt1", dut_b.cnt[1], 2);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
